// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared state enum, entry type, note LUT and constants for piano_sequencer
package piano_pkg;

    localparam int NOTE_W_DEF = 8;
    localparam int DUR_W_DEF  = 12;
    localparam int NOTE_NONE  = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REC  = 2'd1,
        PLAY = 2'd2
    } state_t;

    typedef struct packed {
        logic [NOTE_W_DEF-1:0] code;
        logic [DUR_W_DEF-1:0]  dur;
    } entry_t;

    // Scan code of the home-row keys to tone half-period in clock cycles; unmapped keys are silent
    function automatic logic [15:0] note_half_period(input logic [NOTE_W_DEF-1:0] note);
        logic [15:0] hp;
        case (note)
            8'h1C:   hp = 16'd5;
            8'h1B:   hp = 16'd6;
            8'h23:   hp = 16'd7;
            8'h2B:   hp = 16'd8;
            8'h34:   hp = 16'd9;
            8'h33:   hp = 16'd10;
            8'h3B:   hp = 16'd11;
            8'h42:   hp = 16'd12;
            default: hp = 16'd0;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/piano_tone_gen.sv
// rtl/piano_tone_gen.sv - square-wave generator toggling every half_period cycles
module piano_tone_gen #(
    parameter int HP_W = 16
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic [HP_W-1:0] half_period,
    input  logic            enable,
    output logic            sound
);
    logic [HP_W-1:0] cnt_q, cnt_d;
    logic            sound_q, sound_d;

    // Count up to the half-period and flip the output; silence and rewind when disabled or unmapped
    always_comb begin
        cnt_d   = cnt_q;
        sound_d = sound_q;
        if (!enable || half_period == '0) begin
            cnt_d   = '0;
            sound_d = 1'b0;
        end else if (cnt_q == half_period - HP_W'(1)) begin
            cnt_d   = '0;
            sound_d = ~sound_q;
        end else begin
            cnt_d = cnt_q + HP_W'(1);
        end
    end

    // Tone state registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            sound_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sound_q <= sound_d;
        end
    end

    assign sound = sound_q;

endmodule

// File: rtl/piano_sequencer.sv
// rtl/piano_sequencer.sv - record/erase/replay key sequencer with shared tone path; PIANO_SEQ_LOOP_EN makes playback loop
module piano_sequencer
    import piano_pkg::*;
#(
    parameter int NOTE_W   = NOTE_W_DEF,
    parameter int DUR_W    = DUR_W_DEF,
    parameter int DEPTH    = 64,
    parameter int TICK_DIV = 5000,
    parameter int HP_W     = 16
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   record,
    input  logic                   erase,
    input  logic                   play,
    input  logic                   key_valid,
    input  logic [NOTE_W-1:0]      key_code,
    input  logic                   key_release,
    output logic                   sound,
    output logic [NOTE_W-1:0]      out,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic                   busy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);
    localparam int PW = $clog2(TICK_DIV + 1);
    localparam logic [DUR_W-1:0] DUR_MAX = {DUR_W{1'b1}};

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [NOTE_W-1:0] held_q, held_d, out_q, out_d, code_q, code_d, out_prev_q, out_prev_d;
    logic              open_q, open_d, pend_q, pend_d;
    logic [DUR_W-1:0]  dur_q, dur_d, tcnt_q, tcnt_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              rec_q, rec_d, erase_q, erase_d, play_q, play_d;

    entry_t            mem [DEPTH];
    entry_t            wr_entry;
    logic              commit;
    logic              room;
    logic              tick;
    logic              last;
    logic [DUR_W-1:0]  commit_dur;
    logic [DUR_W-1:0]  cur_dur;
    logic              rec_rise, rec_fall, play_rise, erase_rise;
    logic [HP_W-1:0]   half_period;
    logic              tone_en;

    assign rec_rise   = record & ~rec_q;
    assign rec_fall   = ~record & rec_q;
    assign play_rise  = play & ~play_q;
    assign erase_rise = erase & ~erase_q;
    assign tick       = (pre_q == PW'(TICK_DIV - 1));
    assign commit_dur = (dur_q == '0) ? DUR_W'(1) : dur_q;
    assign cur_dur    = DUR_W'(mem[idx_q].dur);
    assign last       = ((CW'(idx_q) + CW'(1)) == count_q);
    assign wr_entry   = '{code: NOTE_W_DEF'(code_q), dur: DUR_W_DEF'(commit_dur)};

    // Next-state logic: live key tracking, mode transitions, recording and timed playback
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        held_d     = held_q;
        code_d     = code_q;
        open_d     = open_q;
        dur_d      = dur_q;
        pre_d      = pre_q;
        idx_d      = idx_q;
        tcnt_d     = tcnt_q;
        pend_d     = 1'b0;
        rec_d      = record;
        erase_d    = erase;
        play_d     = play;
        out_prev_d = out_q;
        commit     = 1'b0;
        room       = 1'b0;

        if (state_q != PLAY && key_valid) begin
            if (!key_release) begin
                held_d = key_code;
            end else if (key_code == held_q) begin
                held_d = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (rec_rise || pend_q) begin
                    state_d = REC;
                    open_d  = 1'b0;
                end else if (play_rise) begin
                    if (count_q != '0) begin
                        state_d = PLAY;
                        idx_d   = '0;
                        pre_d   = '0;
                        tcnt_d  = '0;
                    end
                end else if (erase_rise && count_q != '0) begin
                    count_d = count_q - CW'(1);
                end
            end
            REC: begin
                if (open_q) begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (tick && dur_q != DUR_MAX) begin
                        dur_d = dur_q + DUR_W'(1);
                    end
                end
                if (rec_fall) begin
                    commit  = open_q;
                    open_d  = 1'b0;
                    state_d = IDLE;
                end else if (key_valid && !key_release) begin
                    // An open note is closed by the next make before the new one opens
                    commit = open_q;
                    room   = ((count_q + CW'(open_q)) != CW'(DEPTH));
                    open_d = room;
                    if (room) begin
                        code_d = key_code;
                        dur_d  = '0;
                        pre_d  = '0;
                    end
                end else if (key_valid && key_release && open_q && key_code == code_q) begin
                    commit = 1'b1;
                    open_d = 1'b0;
                end
            end
            PLAY: begin
                if (rec_rise) begin
                    state_d = IDLE;
                    pend_d  = 1'b1;
                end else if (play_rise) begin
                    state_d = IDLE;
                end else begin
                    pre_d = tick ? '0 : pre_q + PW'(1);
                    if (tick) begin
                        if (tcnt_q + DUR_W'(1) == cur_dur) begin
                            tcnt_d = '0;
                            if (last) begin
`ifdef PIANO_SEQ_LOOP_EN
                                idx_d   = '0;
`else
                                state_d = IDLE;
`endif
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end else begin
                            tcnt_d = tcnt_q + DUR_W'(1);
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            count_d = count_q + CW'(1);
        end

        out_d = (state_d == PLAY) ? NOTE_W'(mem[idx_d].code) : held_d;
    end

    // Control, timing and edge-detect registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            count_q    <= '0;
            held_q     <= '0;
            out_q      <= '0;
            out_prev_q <= '0;
            code_q     <= '0;
            open_q     <= 1'b0;
            pend_q     <= 1'b0;
            dur_q      <= '0;
            tcnt_q     <= '0;
            pre_q      <= '0;
            idx_q      <= '0;
            rec_q      <= 1'b0;
            erase_q    <= 1'b0;
            play_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            held_q     <= held_d;
            out_q      <= out_d;
            out_prev_q <= out_prev_d;
            code_q     <= code_d;
            open_q     <= open_d;
            pend_q     <= pend_d;
            dur_q      <= dur_d;
            tcnt_q     <= tcnt_d;
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            rec_q      <= rec_d;
            erase_q    <= erase_d;
            play_q     <= play_d;
        end
    end

    // Sequence buffer; contents need no reset because count gates every read
    always_ff @(posedge clock) begin
        if (commit) begin
            mem[count_q[IW-1:0]] <= wr_entry;
        end
    end

    // The tone generator sits out the cycle in which the note changes so each note starts from a low phase
    assign half_period = HP_W'(note_half_period(NOTE_W_DEF'(out_q)));
    assign tone_en     = (out_q == out_prev_q) && (out_q != NOTE_W'(NOTE_NONE));

    piano_tone_gen #(.HP_W(HP_W)) u_tone (
        .clock       (clock),
        .resetn      (resetn),
        .half_period (half_period),
        .enable      (tone_en),
        .sound       (sound)
    );

    assign out   = out_q;
    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_piano_sequencer.sv
// tb/tb_piano_sequencer.sv - directed self-checking bench for piano_sequencer (TICK_DIV=4, DEPTH=4)
module tb_piano_sequencer;

    logic       clock;
    logic       resetn;
    logic       record;
    logic       erase;
    logic       play;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_release;
    logic       sound;
    logic [7:0] out;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       busy;

    int tests = 0;
    int fails = 0;

    piano_sequencer #(
        .NOTE_W   (8),
        .DUR_W    (12),
        .DEPTH    (4),
        .TICK_DIV (4),
        .HP_W     (16)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .record      (record),
        .erase       (erase),
        .play        (play),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_release (key_release),
        .sound       (sound),
        .out         (out),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic key(input logic [7:0] code, input logic rel);
        key_code    = code;
        key_release = rel;
        key_valid   = 1'b1;
        step();
        key_valid   = 1'b0;
    endtask

    task automatic pulse_erase();
        erase = 1'b1;
        step();
        erase = 1'b0;
        step();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) step();
        tests++;
        if ({count, full, empty, busy, out, sound} !== {3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got count=%0d full=%b empty=%b busy=%b out=%h sound=%b want 0 0 1 0 00 0",
                     count, full, empty, busy, out, sound);
        end
        resetn = 1'b1;
        step();
    endtask

    task automatic test_record();
        int n;
        record = 1'b1;
        step();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL rec_enter: busy=%b want 1", busy); end
        key(8'h1C, 1'b0);
        repeat (40) step();
        key(8'h1C, 1'b1);
        record = 1'b0;
        step();
        tests++;
        if (count !== 3'd1 || busy !== 1'b0) begin
            fails++; $display("FAIL rec_commit: count=%0d busy=%b want 1 0", count, busy);
        end
        play = 1'b1;
        step();
        n = 0;
        while (out === 8'h1C && n < 200) begin n++; step(); end
`ifdef PIANO_SEQ_LOOP_EN
        tests++;
        if (n != 200) begin fails++; $display("FAIL loop_single: left note after %0d cycles want no exit", n); end
        play = 1'b0;
        step();
        play = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL loop_stop: busy=%b want 0", busy); end
`else
        tests++;
        if (n != 40) begin fails++; $display("FAIL play_len: got %0d cycles want 40", n); end
        tests++;
        if (out !== 8'h00 || busy !== 1'b0) begin
            fails++; $display("FAIL play_end: out=%h busy=%b want 00 0", out, busy);
        end
`endif
        play = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5];
        codes = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34};
        pulse_erase();
        tests++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            fails++; $display("FAIL erase_one: count=%0d empty=%b want 0 1", count, empty);
        end
        pulse_erase();
        tests++;
        if (count !== 3'd0 || empty !== 1'b1) begin
            fails++; $display("FAIL erase_empty: count=%0d empty=%b want 0 1", count, empty);
        end
        record = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            key(codes[i], 1'b0);
            repeat (5) step();
            key(codes[i], 1'b1);
        end
        record = 1'b0;
        step();
        tests++;
        if (count !== 3'd4 || full !== 1'b1) begin
            fails++; $display("FAIL overflow: count=%0d full=%b want 4 1", count, full);
        end
        pulse_erase();
        tests++;
        if (count !== 3'd3 || full !== 1'b0) begin
            fails++; $display("FAIL erase_full: count=%0d full=%b want 3 0", count, full);
        end
    endtask

    task automatic test_overlap();
        int n;
        repeat (3) pulse_erase();
        record = 1'b1;
        step();
        key(8'h1C, 1'b0);
        repeat (12) step();
        key(8'h1B, 1'b0);
        key(8'h23, 1'b1);
        repeat (7) step();
        key(8'h1B, 1'b1);
        record = 1'b0;
        step();
        tests++;
        if (count !== 3'd2) begin fails++; $display("FAIL overlap_count: count=%0d want 2", count); end
        play = 1'b1;
        step();
        n = 0;
        while (out === 8'h1C && n < 200) begin n++; step(); end
        tests++;
        if (n != 12) begin fails++; $display("FAIL overlap_e0: got %0d cycles of 1C want 12", n); end
        n = 0;
        while (out === 8'h1B && n < 200) begin n++; step(); end
        tests++;
        if (n != 8) begin fails++; $display("FAIL overlap_e1: got %0d cycles of 1B want 8", n); end
`ifdef PIANO_SEQ_LOOP_EN
        tests++;
        if (out !== 8'h1C || busy !== 1'b1) begin
            fails++; $display("FAIL loop_wrap: out=%h busy=%b want 1C 1", out, busy);
        end
        play = 1'b0;
        step();
        play = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL loop_exit: busy=%b want 0", busy); end
`else
        tests++;
        if (out !== 8'h00 || busy !== 1'b0) begin
            fails++; $display("FAIL overlap_end: out=%h busy=%b want 00 0", out, busy);
        end
`endif
        play = 1'b0;
        step();
    endtask

    task automatic test_abort();
        key(8'h2B, 1'b0);
        play = 1'b1;
        step();
        repeat (13) step();
        tests++;
        if (out !== 8'h1B) begin fails++; $display("FAIL abort_pre: out=%h want 1B", out); end
        play = 1'b0;
        step();
        play = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0 || out !== 8'h2B) begin
            fails++; $display("FAIL abort: busy=%b out=%h want 0 2B", busy, out);
        end
        play = 1'b0;
        step();
        play = 1'b1;
        step();
        tests++;
        if (busy !== 1'b1 || out !== 8'h1C) begin
            fails++; $display("FAIL replay: busy=%b out=%h want 1 1C", busy, out);
        end
        play = 1'b0;
        step();
        play = 1'b1;
        step();
        play = 1'b0;
        step();
        key(8'h2B, 1'b1);
        repeat (2) pulse_erase();
        play = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0 || empty !== 1'b1) begin
            fails++; $display("FAIL play_empty: busy=%b empty=%b want 0 1", busy, empty);
        end
        play = 1'b0;
        step();
    endtask

    task automatic test_tone();
        int k;
        int ones;
        key(8'h1C, 1'b0);
        k = 0;
        while (sound !== 1'b1 && k < 50) begin k++; step(); end
        tests++;
        if (k != 6) begin fails++; $display("FAIL tone_first: toggle after %0d cycles want 6", k); end
        k = 0;
        while (sound !== 1'b0 && k < 50) begin k++; step(); end
        tests++;
        if (k != 5) begin fails++; $display("FAIL tone_high: high for %0d cycles want 5", k); end
        k = 0;
        while (sound !== 1'b1 && k < 50) begin k++; step(); end
        tests++;
        if (k != 5) begin fails++; $display("FAIL tone_low: low for %0d cycles want 5", k); end
        key(8'h1C, 1'b1);
        step();
        tests++;
        if (sound !== 1'b0 || out !== 8'h00) begin
            fails++; $display("FAIL tone_off: sound=%b out=%h want 0 00", sound, out);
        end
        key(8'h7E, 1'b0);
        ones = 0;
        for (int i = 0; i < 30; i++) begin
            if (sound !== 1'b0) ones++;
            step();
        end
        tests++;
        if (ones != 0 || out !== 8'h7E) begin
            fails++; $display("FAIL tone_unmapped: high samples=%0d out=%h want 0 7E", ones, out);
        end
        key(8'h7E, 1'b1);
    endtask

    task automatic test_reset_mid_play();
        record = 1'b1;
        step();
        key(8'h1C, 1'b0);
        repeat (8) step();
        key(8'h1C, 1'b1);
        record = 1'b0;
        step();
        play = 1'b1;
        step();
        record = 1'b1;
        step();
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rec_abort_idle: busy=%b want 0", busy); end
        step();
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL rec_abort_rec: busy=%b want 1", busy); end
        record = 1'b0;
        step();
        tests++;
        if (count !== 3'd1 || busy !== 1'b0) begin
            fails++; $display("FAIL rec_append: count=%0d busy=%b want 1 0", count, busy);
        end
        play = 1'b0;
        step();
        play = 1'b1;
        step();
        repeat (2) step();
        tests++;
        if (busy !== 1'b1 || out !== 8'h1C) begin
            fails++; $display("FAIL mid_play: busy=%b out=%h want 1 1C", busy, out);
        end
        resetn = 1'b0;
        #1;
        tests++;
        if ({count, full, empty, busy, out, sound} !== {3'd0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0}) begin
            fails++;
            $display("FAIL async_reset: got count=%0d full=%b empty=%b busy=%b out=%h sound=%b want 0 0 1 0 00 0",
                     count, full, empty, busy, out, sound);
        end
        play = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        record      = 1'b0;
        erase       = 1'b0;
        play        = 1'b0;
        key_valid   = 1'b0;
        key_code    = 8'h00;
        key_release = 1'b0;
        resetn      = 1'b0;
        test_reset();
        test_record();
        test_overflow();
        test_overlap();
        test_abort();
        test_tone();
        test_reset_mid_play();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/piano_sequencer.md
Name: piano_sequencer

Overview:
- Parametrised successor to the single-voice piano front end.
- Records timed key presses (note code plus duration) into an on-chip buffer, erases the last entry on request, and replays the sequence with exact timing.
- Drives a square-wave tone generator from a note-to-half-period LUT, so live keys and playback share one audio path.
- Sits between the PS/2 key decoder and the audio pin / display driver.

Parameters:
- NOTE_W, 8: key-code width.
- DUR_W, 12: duration width, in ticks.
- DEPTH, 64: number of sequence entries; power of 2, at least 2.
- TICK_DIV, 5000: clock cycles per duration tick (1 ms at 5 MHz).
- HP_W, 16: tone half-period counter width.

Ports:
- clock, in, 1: system clock.
- resetn, in, 1: asynchronous active-low reset.
- record, in, 1: level; rising edge enters REC, falling edge leaves REC.
- erase, in, 1: level; a rising edge in IDLE deletes the last entry.
- play, in, 1: level; a rising edge starts playback, or aborts it while in PLAY.
- key_valid, in, 1: one-cycle pulse qualifying key_code and key_release.
- key_code, in, NOTE_W: decoded key.
- key_release, in, 1: 1 = break event, 0 = make event.
- sound, out, 1: square-wave audio.
- out, out, NOTE_W: note currently sounding (0 = none).
- count, out, $clog2(DEPTH)+1: number of stored entries.
- full, out, 1: count == DEPTH.
- empty, out, 1: count == 0.
- busy, out, 1: state != IDLE.

Behaviour:
- Reset values: state IDLE; count 0; sound 0; out 0; full 0; empty 1; busy 0; held-key register 0; all edge-detect registers 0. Buffer contents are don't-care.
- Edge detect: record, erase and play are registered once; an edge acts on the cycle after the input changes.
- Priority when edges coincide: record > play > erase.
- Live key handling (all states except PLAY):
  - make event: held := key_code.
  - break event: clears held only if key_code == held; otherwise ignored.
  - out = held, valid one cycle after key_valid.
- IDLE:
  - record rise -> REC.
  - play rise with !empty -> PLAY at entry 0; play rise with empty is ignored.
  - erase rise with !empty -> count decrements by 1; with empty, ignored.
- REC:
  - make event when !full: open an entry (code = key_code), clear the duration counter, restart the prescaler.
  - Prescaler: every TICK_DIV cycles the duration increments, saturating at 2^DUR_W-1.
  - Matching break commits the entry {code, max(dur,1)} at index count; count increments.
  - A make event while an entry is open commits the open entry first, then opens the new one in the same cycle.
  - Make events when full are ignored and no entry opens.
  - Record fall commits any open entry, then -> IDLE.
- PLAY:
  - Entry i sounds for exactly dur_i * TICK_DIV cycles; the prescaler restarts at each entry start.
  - out = stored code of the current entry; the live key path is masked.
  - After the last entry (index count-1) -> IDLE; out := held.
  - play rise -> IDLE immediately.
  - record rise -> abort to IDLE, then REC on the next cycle (append).
  - erase is ignored.
- Tone: half-period = LUT(out); sound toggles each time the half-period counter reaches it.
  - LUT miss, or out == 0: half-period 0, sound forced 0, counter held 0.
  - A change of out restarts the counter with sound = 0.
- Asynchronous reset mid-REC or mid-PLAY: open entry discarded, stored entries lost (count = 0).

Optional Feature:
- Macro PIANO_SEQ_LOOP_EN.
- Defined: on finishing the last entry, PLAY wraps to entry 0 with no gap cycle; it exits only on a play or record rise.
- Undefined: playback stops after one pass, as specified above.

Decomposition:
- Package piano_pkg holds:
  - the state enum {IDLE, REC, PLAY};
  - the entry struct {code[NOTE_W], dur[DUR_W]};
  - the note-to-half-period LUT as a function, with default 0;
  - constant NOTE_NONE = 0.
- Sub-module piano_tone_gen: inputs half_period and enable; output sound.
- The buffer is an inferred register array inside the top module.

Test Plan (TICK_DIV=4, DEPTH=4):
- Record: make 0x1C, 10 ticks later break 0x1C, record fall.
  - Required: count=1; entry {0x1C,10}.
  - Play: out=0x1C for exactly 40 cycles, then out=0 and busy=0.
- Overflow: record 5 short notes.
  - Required: count=4, full=1; the 5th make is ignored.
  - Erase rise: count=3, full=0.
  - Erase on empty: no change, empty stays 1.
- Overlap: make 0x1C, 3 ticks, make 0x1B, 2 ticks, break 0x1B.
  - Required: entries {0x1C,3} and {0x1B,2}.
  - A stray break 0x23 is ignored.
- Abort: play rise during entry 1, then play rise again.
  - Required: IDLE next cycle, out = live held key.
  - play rise while empty: stays IDLE.
- Tone: LUT(0x1C)=5.
  - Required: sound period 10 cycles, first toggle 6 cycles after out change.
  - Unmapped code 0x7E: sound stays 0.
- Reset and loop:
  - resetn low mid-PLAY: all outputs at reset values within the same cycle.
  - With PIANO_SEQ_LOOP_EN and 2 entries: entry 0 restarts on the cycle after entry 1 ends.
